// File: rtl/run_dump_ctrl.sv
// Run controller and result dumper: sequences CPU reset, runs the core until
// END_COUNT enabled cycles or a PC-stall halt, then streams RF and data memory out.
module run_dump_ctrl #(
  parameter int unsigned END_COUNT   = 600,
  parameter int unsigned RST_CYCLES  = 1,
  parameter int unsigned HALT_CYCLES = 0,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned NUM_MEM     = 12,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              cpu_rst_n_o,
  output logic              cpu_en_o,
  input  logic [31:0]       pc_i,
  output logic [ADDR_W-1:0] reg_addr_o,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic              dump_sel_o,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [31:0]       cycles_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_RUN, S_DUMP_REG, S_DUMP_MEM, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [31:0]       rst_cnt, rst_cnt_n;
  logic [31:0]       hcnt, hcnt_n;
  logic [31:0]       pc_prev, pc_prev_n;
  logic              pc_vld, pc_vld_n;
  logic              primed, primed_n;
  logic              mem_left, mem_left_n;

  logic              cpu_rst_n_n, cpu_en_n;
  logic [ADDR_W-1:0] reg_addr_n, mem_addr_n, dump_idx_n;
  logic              dump_valid_n, dump_sel_n;
  logic [DATA_W-1:0] dump_data_n;
  logic [31:0]       cycles_n;
  logic              busy_n, halted_n, done_n;

  logic [31:0]       cyc_inc, hcnt_inc;
  logic              halt_hit, end_hit, can_load;

  always_comb begin
    state_n      = state;
    rst_cnt_n    = rst_cnt;
    hcnt_n       = hcnt;
    pc_prev_n    = pc_prev;
    pc_vld_n     = pc_vld;
    primed_n     = primed;
    mem_left_n   = mem_left;
    cpu_rst_n_n  = cpu_rst_n_o;
    cpu_en_n     = cpu_en_o;
    reg_addr_n   = reg_addr_o;
    mem_addr_n   = mem_addr_o;
    dump_valid_n = dump_valid_o;
    dump_sel_n   = dump_sel_o;
    dump_idx_n   = dump_idx_o;
    dump_data_n  = dump_data_o;
    cycles_n     = cycles_o;
    halted_n     = halted_o;
    cyc_inc      = (cycles_o == '1) ? cycles_o : cycles_o + 32'd1;
    hcnt_inc     = (pc_vld && (pc_i == pc_prev)) ? hcnt + 32'd1 : '0;
    halt_hit     = 1'b0;
    end_hit      = 1'b0;
    can_load     = !dump_valid_o || dump_ready_i;

    case (state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_n     = S_RESET;
          rst_cnt_n   = '0;
          hcnt_n      = '0;
          pc_vld_n    = 1'b0;
          primed_n    = 1'b0;
          mem_left_n  = 1'b1;
          cpu_rst_n_n = 1'b0;
          cpu_en_n    = 1'b0;
          reg_addr_n  = '0;
          mem_addr_n  = '0;
          dump_sel_n  = 1'b0;
          dump_idx_n  = '0;
          dump_data_n = '0;
          cycles_n    = '0;
          halted_n    = 1'b0;
        end
      end
      S_RESET: begin
        if (rst_cnt == RST_CYCLES - 1) begin
          state_n     = S_RUN;
          cpu_rst_n_n = 1'b1;
          cpu_en_n    = 1'b1;
        end else begin
          rst_cnt_n = rst_cnt + 32'd1;
        end
      end
      S_RUN: begin
        cycles_n  = cyc_inc;
        pc_prev_n = pc_i;
        pc_vld_n  = 1'b1;
        if (HALT_CYCLES != 0) begin
          hcnt_n   = hcnt_inc;
          halt_hit = (hcnt_inc == HALT_CYCLES);
        end
        end_hit = (cyc_inc == END_COUNT);
        if (halt_hit || end_hit) begin
          state_n  = S_DUMP_REG;
          cpu_en_n = 1'b0;
          halted_n = halt_hit;
        end
      end
      S_DUMP_REG: begin
        // one settle cycle after the freeze edge before the first RF read is captured
        if (!primed) begin
          primed_n = 1'b1;
        end else if (can_load) begin
          dump_valid_n = 1'b1;
          dump_sel_n   = 1'b0;
          dump_idx_n   = reg_addr_o;
          dump_data_n  = reg_data_i;
          if (reg_addr_o == ADDR_W'(NUM_REGS - 1)) state_n = S_DUMP_MEM;
          else reg_addr_n = reg_addr_o + 1'b1;
        end
      end
      S_DUMP_MEM: begin
        if (can_load) begin
          if (mem_left) begin
            dump_valid_n = 1'b1;
            dump_sel_n   = 1'b1;
            dump_idx_n   = mem_addr_o;
            dump_data_n  = mem_data_i;
            if (mem_addr_o == ADDR_W'(NUM_MEM - 1)) mem_left_n = 1'b0;
            else mem_addr_n = mem_addr_o + 1'b1;
          end else begin
            dump_valid_n = 1'b0;
            state_n      = S_DONE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_RESET) || (state_n == S_RUN) ||
             (state_n == S_DUMP_REG) || (state_n == S_DUMP_MEM);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      rst_cnt      <= '0;
      hcnt         <= '0;
      pc_prev      <= '0;
      pc_vld       <= 1'b0;
      primed       <= 1'b0;
      mem_left     <= 1'b1;
      cpu_rst_n_o  <= 1'b0;
      cpu_en_o     <= 1'b0;
      reg_addr_o   <= '0;
      mem_addr_o   <= '0;
      dump_valid_o <= 1'b0;
      dump_sel_o   <= 1'b0;
      dump_idx_o   <= '0;
      dump_data_o  <= '0;
      cycles_o     <= '0;
      busy_o       <= 1'b0;
      halted_o     <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state        <= state_n;
      rst_cnt      <= rst_cnt_n;
      hcnt         <= hcnt_n;
      pc_prev      <= pc_prev_n;
      pc_vld       <= pc_vld_n;
      primed       <= primed_n;
      mem_left     <= mem_left_n;
      cpu_rst_n_o  <= cpu_rst_n_n;
      cpu_en_o     <= cpu_en_n;
      reg_addr_o   <= reg_addr_n;
      mem_addr_o   <= mem_addr_n;
      dump_valid_o <= dump_valid_n;
      dump_sel_o   <= dump_sel_n;
      dump_idx_o   <= dump_idx_n;
      dump_data_o  <= dump_data_n;
      cycles_o     <= cycles_n;
      busy_o       <= busy_n;
      halted_o     <= halted_n;
      done_o       <= done_n;
    end
  end

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Scoreboard bench for run_dump_ctrl: stub RF/memory, PC stimulus for halt
// detection, decoupled monitor checking dump items in order.
module tb_run_dump_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          dump_ready_i = 1'b1;
  logic [31:0]   pc_i;
  logic [AW-1:0] reg_addr_o, mem_addr_o, dump_idx_o;
  logic [DW-1:0] reg_data_i, mem_data_i, dump_data_o;
  logic          cpu_rst_n_o, cpu_en_o, dump_valid_o, dump_sel_o;
  logic          busy_o, halted_o, done_o;
  logic [31:0]   cycles_o;

  int ntests = 0;
  int nfail  = 0;
  logic [37:0] sb[$];

  logic [31:0] ecnt = '0;
  logic [31:0] run_base = '0;
  int          hf = 0;

  always #5 clk = ~clk;

  assign reg_data_i = 32'd100 + 32'(reg_addr_o);
  assign mem_data_i = 32'hA000 + 32'(mem_addr_o);

  always @(posedge clk) if (cpu_en_o) ecnt <= ecnt + 32'd1;
  // PC advances every enabled cycle; from enabled cycle hf it sticks at 0x40
  assign pc_i = (hf != 0 && (ecnt - run_base) >= 32'(hf - 1)) ? 32'h40 : 32'h100 + (ecnt << 2);

  run_dump_ctrl #(
    .END_COUNT(20), .RST_CYCLES(2), .HALT_CYCLES(3), .DATA_W(DW),
    .NUM_REGS(4), .NUM_MEM(2), .ADDR_W(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .cpu_rst_n_o(cpu_rst_n_o), .cpu_en_o(cpu_en_o), .pc_i(pc_i),
    .reg_addr_o(reg_addr_o), .reg_data_i(reg_data_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_sel_o(dump_sel_o), .dump_idx_o(dump_idx_o), .dump_data_o(dump_data_o),
    .cycles_o(cycles_o), .busy_o(busy_o), .halted_o(halted_o), .done_o(done_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stalled items hold.
  logic        hold = 1'b0;
  logic [37:0] held;
  logic [37:0] item;
  always @(negedge clk) begin
    if (rst_i) begin
      hold = 1'b0;
    end else begin
      item = {dump_sel_o, dump_idx_o, dump_data_o};
      if (hold) check("stall_stable", {25'd0, dump_valid_o, item}, {25'd0, 1'b1, held});
      if (dump_valid_o && dump_ready_i) begin
        if (sb.size() == 0) check("unexpected_item", {26'd0, item}, 64'hDEAD);
        else check("dump_item", {26'd0, item}, {26'd0, sb.pop_front()});
        hold = 1'b0;
      end else if (dump_valid_o) begin
        hold = 1'b1;
        held = item;
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_cpu_rst_n", cpu_rst_n_o, 0);
    check("rst_cpu_en", cpu_en_o, 0);
    check("rst_valid", dump_valid_o, 0);
    check("rst_sel", dump_sel_o, 0);
    check("rst_idx", dump_idx_o, 0);
    check("rst_data", dump_data_o, 0);
    check("rst_cycles", cycles_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_halted", halted_o, 0);
    check("rst_done", done_o, 0);
    check("rst_reg_addr", reg_addr_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
  endtask

  // One run: start pulse (or start held through RUN), watch until done_o.
  task automatic do_run(input int halt_from, input bit toggle, input bit hold_start,
                        input int abort_after, input int exp_en, input bit exp_halt);
    int lo = 0, en = 0, vcnt = 0, acc = 0, gap = 0, lat = -1;
    bit prev_en = 0, exited = 0, first = 1, fin = 0;
    hf = halt_from;
    run_base = ecnt;
    for (int r = 0; r < 4; r++) sb.push_back({1'b0, AW'(r), 32'(100 + r)});
    for (int m = 0; m < 2; m++) sb.push_back({1'b1, AW'(m), 32'hA000 + 32'(m)});
    @(posedge clk); #1;
    start_i = 1'b1;
    dump_ready_i = 1'b1;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(posedge clk); #1;
      start_i = hold_start && !exited;
      if (toggle) dump_ready_i = ~dump_ready_i;
      if (abort_after != 0 && acc == abort_after) begin
        rst_i = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst_i = 1'b0;
        start_i = 1'b0;
        dump_ready_i = 1'b1;
        return;
      end
      @(negedge clk);
      if (first) check("cycles_cleared", cycles_o, 0);
      first = 0;
      if (busy_o && !cpu_rst_n_o) lo++;
      if (cpu_en_o) en++;
      if (dump_valid_o) vcnt++;
      if (dump_valid_o && dump_ready_i) acc++;
      if (prev_en && !cpu_en_o) exited = 1;
      if (exited && lat < 0) begin
        if (dump_valid_o) lat = gap;
        else gap++;
      end
      prev_en = cpu_en_o;
      fin = done_o;
    end
    start_i = 1'b0;
    if (!fin) begin
      check("timeout_done", 0, 1);
      return;
    end
    check("rst_low_cycles", lo, 2);
    check("en_cycles", en, exp_en);
    check("first_valid_lat", lat, 2);
    check("cycles_o", cycles_o, exp_en);
    check("halted_o", halted_o, exp_halt);
    check("done_busy", {done_o, busy_o}, 2'b10);
    check("frozen_cpu", {cpu_rst_n_o, cpu_en_o, dump_valid_o}, 3'b100);
    check("sb_empty", sb.size(), 0);
    if (!toggle) check("valid_burst", vcnt, 6);
    dump_ready_i = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check_reset_vals();

    do_run(0, 0, 0, 0, 20, 0);   // full END_COUNT run, ready held high
    do_run(0, 1, 0, 0, 20, 0);   // ready toggling during dump
    do_run(5, 0, 0, 0, 8, 1);    // PC stall from enabled cycle 5
    do_run(17, 0, 0, 0, 20, 1);  // halt coincides with END_COUNT
    do_run(0, 0, 0, 2, 0, 0);    // reset after 2 accepted items
    do_run(0, 0, 0, 0, 20, 0);   // rerun from IDLE dumps from reg 0
    do_run(0, 1, 1, 0, 20, 0);   // start held during RUN
    do_run(0, 0, 0, 0, 20, 0);   // restart from DONE

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/run_dump_ctrl.md
Name: run_dump_ctrl

Overview:
- Synthesizable run controller and result dumper for Simple_Single_CPU-class cores.
- Sequences CPU reset, runs the core for a bounded cycle count or until a PC-stall halt, then freezes it.
- Streams the register-file and data-memory contents out over a valid/ready port.
- Sits between the top-level harness and the CPU, using the CPU's RF and data-memory read ports.

Parameters:
END_COUNT, 600, enabled CPU cycles before forced stop (≥1)
RST_CYCLES, 1, cycles cpu_rst_n_o is held low before run (≥1)
HALT_CYCLES, 0, consecutive cycles of unchanged pc_i that declare a halt; 0 disables halt detection
DATA_W, 32, register/memory word width
NUM_REGS, 32, registers dumped, indices 0..NUM_REGS-1
NUM_MEM, 12, memory words dumped, word addresses 0..NUM_MEM-1
ADDR_W, 5, width of reg_addr_o, mem_addr_o and dump_idx_o

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
start_i  in  1  start a run; pulse or level
cpu_rst_n_o  out  1  active-low reset to CPU rst_i
cpu_en_o  out  1  CPU clock-enable/run
pc_i  in  32  CPU program counter, for halt detection
reg_addr_o  out  ADDR_W  RF read address
reg_data_i  in  DATA_W  RF read data, combinational from reg_addr_o
mem_addr_o  out  ADDR_W  data-memory word address
mem_data_i  in  DATA_W  data-memory read data, combinational
dump_valid_o  out  1  dump item valid
dump_ready_i  in  1  consumer ready
dump_sel_o  out  1  0 = register item, 1 = memory item
dump_idx_o  out  ADDR_W  register index or memory word address of the item
dump_data_o  out  DATA_W  item value
cycles_o  out  32  enabled cycles executed in this run
busy_o  out  1  high in RESET, RUN, DUMP_REG, DUMP_MEM
halted_o  out  1  run ended by halt detection rather than END_COUNT
done_o  out  1  dump complete

Behaviour:
- Reset (rst_i=1 at posedge) values: state IDLE, cpu_rst_n_o=0, cpu_en_o=0, dump_valid_o=0, dump_sel_o=0, dump_idx_o=0, dump_data_o=0, cycles_o=0, busy_o=0, halted_o=0, done_o=0, reg_addr_o=0, mem_addr_o=0.
- Reset mid-run or mid-dump aborts immediately. Any pending item is dropped.
- All outputs are registered.
- IDLE: start_i=1 -> RESET. Clears cycles_o, halted_o, done_o and the item index.
- RESET:
  - cpu_rst_n_o=0 and cpu_en_o=0 for exactly RST_CYCLES cycles.
  - Then -> RUN with cpu_rst_n_o=1 and cpu_en_o=1 on the same edge.
- RUN:
  - cycles_o increments on every edge while cpu_en_o=1.
  - The edge where cycles_o becomes END_COUNT -> DUMP_REG; cpu_en_o=0 from that edge.
  - Halt detection (HALT_CYCLES>0): a counter increments when pc_i equals the pc sampled on the previous enabled cycle, and clears otherwise.
  - When that counter reaches HALT_CYCLES -> DUMP_REG, halted_o=1.
  - If halt and END_COUNT occur on the same edge, halted_o=1.
  - cpu_rst_n_o remains 1 after RUN, so CPU state stays frozen and readable.
- DUMP_REG / DUMP_MEM:
  - One-entry output register. It loads when (dump_valid_o=0 or dump_ready_i=1) and items remain.
  - On load: dump_data_o takes reg_data_i or mem_data_i at the current address, dump_idx_o takes that address, dump_sel_o is set, and the address advances.
  - Items are emitted strictly in order: regs 0..NUM_REGS-1, then mem 0..NUM_MEM-1.
  - First item is valid 2 cycles after the RUN exit edge.
  - Throughput is 1 item/cycle with dump_ready_i held high.
  - While valid=1 and ready=0: dump_data_o, dump_idx_o and dump_sel_o hold stable.
  - Valid never deasserts without a handshake, except on reset.
  - Address counters never exceed NUM_REGS-1 / NUM_MEM-1; they do not wrap.
  - After the final mem item is accepted: dump_valid_o=0, then -> DONE.
- DONE:
  - done_o=1, busy_o=0. cycles_o and halted_o hold.
  - start_i=1 -> RESET, which starts a new run.
- start_i is ignored in RESET, RUN, DUMP_REG and DUMP_MEM.
- The cycles_o counter saturates at 2^32-1. This is unreachable for legal END_COUNT.

Test Plan:
- END_COUNT=20, RST_CYCLES=2, HALT_CYCLES=0, start pulse -> cpu_rst_n_o low for 2 cycles; cpu_en_o high for exactly 20 cycles; cycles_o=20, halted_o=0.
- Stub RF returns 100+idx, mem returns 0xA000+addr, NUM_REGS=4, NUM_MEM=2, ready=1 -> 6 consecutive valid cycles: (0,0,100)…(0,3,103),(1,0,0xA000),(1,1,0xA001); then done_o=1.
- Ready toggled 1/0 every cycle during dump -> same 6 items in order, no loss or duplication; data stable across ready=0 cycles.
- HALT_CYCLES=3, pc_i constant 0x40 from enabled cycle 5, END_COUNT=100 -> halted_o=1; dump starts with cycles_o<100 (cycles_o=8).
- rst_i=1 for one cycle mid-dump (after 2 items) -> all outputs at reset values next cycle; a new start reruns from RESET and dumps from reg 0.
- start_i held high during RUN, then asserted again in DONE -> no effect during RUN; a second full run with cycles_o restarted from 0.
